note_player: RTL and testbench
==============================

Name: note_player

Overview:
- Stage directly downstream of the song reader.
- Accepts one note (pitch index plus duration in beats) per new_note pulse and holds it for the requested number of beat ticks.
- While a note plays, outputs the phase-increment step size for the downstream sine/sample generator.
- Pulses note_done when the note expires, so the song reader can issue the next note.

Parameters:
- DUR_WIDTH, 6, width of the duration input and internal beat counter.
- STEP_WIDTH, 20, width of step_size output (phase accumulator increment).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- play  in  1  1 = run, 0 = pause.
- note  in  6  pitch index; 0 = rest, 1..63 = chromatic pitches.
- duration  in  DUR_WIDTH  note length in beats.
- new_note  in  1  single-cycle load strobe for note/duration.
- beat  in  1  single-cycle beat tick (e.g. 48 Hz), synchronous to clk.
- note_done  out  1  single-cycle pulse when the current note expires.
- step_size  out  STEP_WIDTH  phase increment for the sample generator; 0 = silence.
- busy  out  1  high while a note is loaded and not yet expired.

Behaviour:
- Reset (reset low, async): state IDLE, counter 0, latched note 0; outputs note_done=0, step_size=0, busy=0.
- States: IDLE, PLAYING, DONE.
- IDLE:
  - On new_note: latch note and duration, counter=duration, go to PLAYING.
  - If duration==0, go to DONE instead.
- PLAYING:
  - On beat with play=1: counter decrements.
  - When a beat arrives with counter==1: go to DONE.
  - Beats while play=0 are ignored; the counter freezes.
- DONE: note_done=1 for exactly one cycle, then go to IDLE.
- new_note while PLAYING or DONE:
  - Reloads note, duration and counter; goes to PLAYING (or DONE if duration==0).
  - Any pending note_done from the old note is suppressed.
- new_note and the final beat in the same cycle: the load wins, and no note_done is issued for the old note.
- Latency:
  - new_note at cycle T: step_size and busy valid at T+1.
  - Final beat at cycle T: note_done high at T+1, busy low at T+2.
- step_size (registered):
  - Equals table(latched note) when state is PLAYING and play=1; otherwise 0.
  - DONE, IDLE and pause all force 0.
- Frequency table:
  - Internal 63-entry constant ROM.
  - f(n) = 55 * 2^((n-1)/12) Hz; step = round(f * 2^20 / 48000).
  - Example entries: n=1: 1201; n=25: 4806; n=37: 9612.
  - Note 0 (rest): step 0, but timing counts normally and note_done still pulses.
- busy=1 in PLAYING and DONE; 0 in IDLE.
- Counter arithmetic is unsigned DUR_WIDTH and never underflows; the max duration 63 requires 63 beats.
- beat is not edge-detected; the producer guarantees single-cycle pulses.
- Reset asserted mid-note: immediate return to reset values; no note_done is emitted.

Optional Feature:
- Macro: NOTE_PLAYER_ARTICULATION_EN.
- Defined:
  - During the last beat period of a note (counter==1 in PLAYING), step_size is forced to 0.
  - This creates an audible gap between repeated notes. Timing and note_done are unchanged.
  - For duration==1, the note is silent for its whole length.
- Undefined: step_size holds the table value for the entire PLAYING period.

Test Plan:
- Load note=37, duration=3, play=1, issue 3 beats 10 cycles apart:
  - step_size=9612 from the cycle after the load.
  - note_done single pulse one cycle after the 3rd beat.
  - step_size=0 and busy=0 afterwards.
- Load note=25, duration=4, drop play after 1 beat, send 5 beats, raise play, send 3 beats:
  - step_size=0 while paused.
  - note_done only after the 3rd beat following resume (4 counted beats total).
- Load duration=0 (note=1): note_done pulses at T+1 with no beat needed; step_size stays 0.
- Load note=1, duration=5, then issue new_note (note=25, duration=2) in the same cycle as the 2nd beat:
  - No note_done for the first note.
  - step_size=4806.
  - note_done after 2 further beats.
- Assert reset low mid-note (counter=2): outputs immediately 0, no note_done, further beats ignored until the next new_note.
- With NOTE_PLAYER_ARTICULATION_EN, note=37, duration=2:
  - step_size=9612 after the load.
  - step_size=0 after the 1st beat.
  - note_done after the 2nd beat.

Source files
------------

// File: rtl/note_player.sv
// Note player: holds one note for a number of beat ticks and drives the phase step.
// Optional build macro NOTE_PLAYER_ARTICULATION_EN silences the last beat of each note.
module note_player #(
  parameter int DUR_WIDTH  = 6,
  parameter int STEP_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic [5:0]            note,
  input  logic [DUR_WIDTH-1:0]  duration,
  input  logic                  new_note,
  input  logic                  beat,
  output logic                  note_done,
  output logic [STEP_WIDTH-1:0] step_size,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  // Strobes only, no ready: a new_note pulse is always accepted and overrides
  // whatever note is in flight; beat is a one-cycle tick from the tempo source.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DUR_WIDTH-1:0]    cnt_q, cnt_d;
  logic [5:0]              note_q, note_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d;
  logic                    done_q, busy_q;

  // step = round(55 * 2^((n-1)/12) * 2^20 / 48000); entry 0 is the rest.
  function automatic logic [STEP_WIDTH-1:0] step_rom(input logic [5:0] n);
    logic [19:0] v;
    case (n)
      6'd1:  v = 20'd1201;  6'd2:  v = 20'd1273;  6'd3:  v = 20'd1349;  6'd4:  v = 20'd1429;
      6'd5:  v = 20'd1514;  6'd6:  v = 20'd1604;  6'd7:  v = 20'd1699;  6'd8:  v = 20'd1800;
      6'd9:  v = 20'd1907;  6'd10: v = 20'd2021;  6'd11: v = 20'd2141;  6'd12: v = 20'd2268;
      6'd13: v = 20'd2403;  6'd14: v = 20'd2546;  6'd15: v = 20'd2697;  6'd16: v = 20'd2858;
      6'd17: v = 20'd3028;  6'd18: v = 20'd3208;  6'd19: v = 20'd3398;  6'd20: v = 20'd3600;
      6'd21: v = 20'd3815;  6'd22: v = 20'd4041;  6'd23: v = 20'd4282;  6'd24: v = 20'd4536;
      6'd25: v = 20'd4806;  6'd26: v = 20'd5092;  6'd27: v = 20'd5395;  6'd28: v = 20'd5715;
      6'd29: v = 20'd6055;  6'd30: v = 20'd6415;  6'd31: v = 20'd6797;  6'd32: v = 20'd7201;
      6'd33: v = 20'd7629;  6'd34: v = 20'd8083;  6'd35: v = 20'd8563;  6'd36: v = 20'd9072;
      6'd37: v = 20'd9612;  6'd38: v = 20'd10184; 6'd39: v = 20'd10789; 6'd40: v = 20'd11431;
      6'd41: v = 20'd12110; 6'd42: v = 20'd12830; 6'd43: v = 20'd13593; 6'd44: v = 20'd14402;
      6'd45: v = 20'd15258; 6'd46: v = 20'd16165; 6'd47: v = 20'd17127; 6'd48: v = 20'd18145;
      6'd49: v = 20'd19224; 6'd50: v = 20'd20367; 6'd51: v = 20'd21578; 6'd52: v = 20'd22861;
      6'd53: v = 20'd24221; 6'd54: v = 20'd25661; 6'd55: v = 20'd27187; 6'd56: v = 20'd28803;
      6'd57: v = 20'd30516; 6'd58: v = 20'd32331; 6'd59: v = 20'd34253; 6'd60: v = 20'd36290;
      6'd61: v = 20'd38448; 6'd62: v = 20'd40734; 6'd63: v = 20'd43156;
      default: v = 20'd0;
    endcase
    return STEP_WIDTH'(v);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    if (new_note) begin
      note_d  = note;
      cnt_d   = duration;
      state_d = (duration == '0) ? DONE : PLAYING;
    end else begin
      case (state_q)
        PLAYING: begin
          if (beat && play) begin
            if (cnt_q <= DUR_WIDTH'(1)) begin
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q - DUR_WIDTH'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered from the next state so a load is visible one cycle later.
    step_d = '0;
    if (state_d == PLAYING && play) begin
      step_d = step_rom(note_d);
    end
`ifdef NOTE_PLAYER_ARTICULATION_EN
    if (cnt_d == DUR_WIDTH'(1)) begin
      step_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      note_q  <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
      step_q  <= step_d;
      done_q  <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign note_done   = done_q;
  assign step_size   = step_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: directed scenarios plus randomized traffic
// compared every cycle against a note-level behavioural model.
module tb_note_player;

  localparam int DW = 6;
  localparam int SW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          play = 1'b0;
  logic [5:0]    note = '0;
  logic [DW-1:0] duration = '0;
  logic          new_note = 1'b0;
  logic          beat = 1'b0;
  logic          note_done;
  logic [SW-1:0] step_size;
  logic          busy;
  logic [1:0]    dbg_state;

  note_player #(.DUR_WIDTH(DW), .STEP_WIDTH(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .note       (note),
    .duration   (duration),
    .new_note   (new_note),
    .beat       (beat),
    .note_done  (note_done),
    .step_size  (step_size),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int freq [0:63];
  bit m_active;
  int m_rem;
  int m_pitch;
  bit e_done;
  bit e_busy;
  int e_step;

  task automatic build_freq();
    real f;
    f = 55.0 * 1048576.0 / 48000.0;
    freq[0] = 0;
    for (int n = 1; n < 64; n++) begin
      freq[n] = $rtoi(f + 0.5);
      f = f * 1.0594630943592953;
    end
  endtask

  task automatic model_clear();
    m_active = 1'b0;
    m_rem    = 0;
    m_pitch  = 0;
    e_done   = 1'b0;
    e_busy   = 1'b0;
    e_step   = 0;
  endtask

  // A note is a pitch plus a count of beats still owed; it ends when that count hits zero.
  always @(posedge clk) begin
    if (!reset) begin
      model_clear();
    end else begin
      e_done = 1'b0;
      if (new_note) begin
        m_pitch  = int'(note);
        m_rem    = int'(duration);
        m_active = (duration != 0);
        e_done   = (duration == 0);
      end else if (m_active && beat && play) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_active = 1'b0;
          e_done   = 1'b1;
        end
      end
      e_busy = m_active || e_done;
      e_step = (m_active && play) ? freq[m_pitch] : 0;
`ifdef NOTE_PLAYER_ARTICULATION_EN
      if (m_active && m_rem == 1) e_step = 0;
`endif
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (!reset) model_clear();
      check("sb_note_done", int'(note_done), int'(e_done));
      check("sb_busy", int'(busy), int'(e_busy));
      check("sb_step_size", int'(step_size), e_step);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input int n, input int d);
    note     = 6'(n);
    duration = DW'(d);
    new_note = 1'b1;
    tick();
    new_note = 1'b0;
  endtask

  task automatic beat_pulse();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    build_freq();
    check("model_f1", freq[1], 1201);
    check("model_f25", freq[25], 4806);
    check("model_f37", freq[37], 9612);

    reset = 1'b0;
    idle(3);
    chk_en = 1'b1;
    check("reset_step", int'(step_size), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(note_done), 0);
    reset = 1'b1;
    play  = 1'b1;
    idle(2);

    // basic note: 37 for 3 beats
    load(37, 3);
    check("t1_step_after_load", int'(step_size), 9612);
    check("t1_busy_after_load", int'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) idle(9);
      beat_pulse();
    end
    check("t1_done_pulse", int'(note_done), 1);
    check("t1_busy_in_done", int'(busy), 1);
    tick();
    check("t1_done_cleared", int'(note_done), 0);
    check("t1_busy_low", int'(busy), 0);
    check("t1_step_zero", int'(step_size), 0);
    idle(3);

    // pause freezes the count
    load(25, 4);
    beat_pulse();
    idle(2);
    play = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      beat_pulse();
      idle(2);
    end
    check("t2_step_paused", int'(step_size), 0);
    check("t2_busy_paused", int'(busy), 1);
    play = 1'b1;
    idle(2);
    check("t2_step_resumed", int'(step_size), 4806);
    for (int i = 0; i < 3; i++) begin
      beat_pulse();
      if (i < 2) begin
        check("t2_no_early_done", int'(note_done), 0);
        idle(9);
      end
    end
    check("t2_done_after_4", int'(note_done), 1);
    idle(3);

    // zero duration finishes without any beat
    load(1, 0);
    check("t3_done_now", int'(note_done), 1);
    check("t3_step_zero", int'(step_size), 0);
    tick();
    check("t3_busy_low", int'(busy), 0);
    idle(3);

    // reload on the final beat of nothing; load wins over a coincident beat
    load(1, 5);
    beat_pulse();
    idle(3);
    note = 6'd25; duration = DW'(2); new_note = 1'b1; beat = 1'b1;
    tick();
    new_note = 1'b0; beat = 1'b0;
    check("t4_no_done_old", int'(note_done), 0);
    check("t4_step_new", int'(step_size), 4806);
    idle(3);
    beat_pulse();
    check("t4_not_yet", int'(note_done), 0);
    idle(3);
    beat_pulse();
    check("t4_done", int'(note_done), 1);
    idle(3);

    // async reset mid-note
    load(37, 3);
    beat_pulse();
    tick();
    #1 reset = 1'b0;
    #1;
    check("t5_step_reset", int'(step_size), 0);
    check("t5_busy_reset", int'(busy), 0);
    check("t5_done_reset", int'(note_done), 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat_pulse();
      check("t5_beats_ignored", int'(busy) + int'(note_done) + int'(step_size), 0);
      idle(2);
    end

    // articulation gap on the last beat
    load(37, 2);
    check("t6_step_load", int'(step_size), 9612);
    beat_pulse();
`ifdef NOTE_PLAYER_ARTICULATION_EN
    check("t6_step_last_beat", int'(step_size), 0);
`else
    check("t6_step_last_beat", int'(step_size), 9612);
`endif
    check("t6_busy", int'(busy), 1);
    beat_pulse();
    check("t6_done", int'(note_done), 1);
    idle(3);

    // maximum duration needs all 63 beats
    load(5, 63);
    for (int i = 0; i < 62; i++) begin
      beat_pulse();
      tick();
    end
    check("t7_busy_at_62", int'(busy), 1);
    check("t7_no_done_62", int'(note_done), 0);
    beat_pulse();
    check("t7_done_at_63", int'(note_done), 1);
    idle(3);

    // every pitch once
    for (int n = 0; n < 64; n++) begin
      load(n, 2);
      tick();
    end
    idle(6);

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      new_note = ($urandom_range(0, 7) == 0);
      note     = 6'($urandom_range(0, 63));
      duration = ($urandom_range(0, 9) == 0) ? DW'($urandom_range(0, 63)) : DW'($urandom_range(0, 4));
      beat     = !beat && ($urandom_range(0, 2) == 0);
      play     = ($urandom_range(0, 9) != 0);
      reset    = ($urandom_range(0, 799) != 0);
      tick();
    end
    new_note = 1'b0;
    beat     = 1'b0;
    reset    = 1'b1;
    idle(4);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
